// File: rtl/rtc_burst_reader_if.sv
//------------------------------------------------------------------------------
// Module      : rtc_burst_reader_if
// Description : Request/strobe bundle between the RTC burst reader (master)
//               and the multiplexed address/data bus-cycle engine (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rtc_burst_reader_if #(
  parameter int DW = 8
);
  logic          bus_req;
  logic [DW-1:0] bus_out;
  logic          bus_wr;
  logic          addr_ph;
  logic          data_ph;
  logic          cyc_done;
  logic [DW-1:0] rd_data;

  modport master (
    output bus_req, bus_out, bus_wr,
    input  addr_ph, data_ph, cyc_done, rd_data
  );

  modport slave (
    input  bus_req, bus_out, bus_wr,
    output addr_ph, data_ph, cyc_done, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/rtc_burst_reader.sv
//------------------------------------------------------------------------------
// Module      : rtc_burst_reader
// Description : Issues the RTC "transfer to RAM" command, then reads the
//               masked subset of a runtime address table into shadow
//               registers and commits them as one snapshot at burst end.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtc_burst_reader #(
  parameter int          DW        = 8,
  parameter int          NREG      = 6,
  parameter logic [7:0]  CMD_CLK   = 8'hF1,
  parameter logic [7:0]  CMD_TMR   = 8'hF2,
  parameter logic [7:0]  CMD_DATA  = 8'h01,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF,
  parameter int          TIMEOUT   = 1023
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 start,
  input  wire logic                 mode_timer,
  input  wire logic [NREG-1:0]      reg_mask,
  input  wire logic [NREG*DW-1:0]   addr_tab,
  rtc_burst_reader_if.master        bus,
  output logic      [NREG*DW-1:0]   regs_out,
  output logic      [NREG-1:0]      valid_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int              c_IW        = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(NREG - 1);
  localparam logic [15:0]     c_TMO_LAST  = 16'(TIMEOUT - 1);
  // Timer mode only exposes the first three table entries.
  localparam logic [NREG-1:0] c_TMR_MASK  = NREG'(7);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CMD    = 3'd1;
  localparam logic [2:0] c_ST_SEL    = 3'd2;
  localparam logic [2:0] c_ST_READ   = 3'd3;
  localparam logic [2:0] c_ST_COMMIT = 3'd4;

  logic [2:0]                 r_state, w_state_nxt;
  logic [c_IW-1:0]            r_idx, w_idx_nxt;
  logic                       r_mode, w_mode_nxt;
  logic [NREG-1:0]            r_emask, w_emask_nxt;
  logic [15:0]                r_tmr, w_tmr_nxt;
  logic [NREG-1:0][DW-1:0]    r_shadow, w_shadow_nxt;
  logic [NREG-1:0][DW-1:0]    r_regs, w_regs_nxt;
  logic [NREG-1:0]            r_valid, w_valid_nxt;
  logic                       r_bus_req, w_bus_req_nxt;
  logic [DW-1:0]              r_bus_out, w_bus_out_nxt;
  logic                       r_bus_wr, w_bus_wr_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_done, w_done_nxt;
  logic                       r_error, w_error_nxt;

  // Strobe priority: address phase beats data phase beats end-of-cycle.
  logic w_addr, w_data, w_cdone, w_any, w_tmo, w_last;
  assign w_addr  = bus.addr_ph;
  assign w_data  = bus.data_ph & ~bus.addr_ph;
  assign w_cdone = bus.cyc_done & ~bus.addr_ph & ~bus.data_ph;
  assign w_any   = bus.addr_ph | bus.data_ph | bus.cyc_done;
  assign w_tmo   = ~w_any & (r_tmr == c_TMO_LAST);
  assign w_last  = (r_idx == c_LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (start) w_state_nxt = c_ST_CMD;
      c_ST_CMD:    if (w_tmo) w_state_nxt = c_ST_IDLE;
                   else if (w_cdone) w_state_nxt = c_ST_SEL;
      c_ST_SEL:    if (r_emask[r_idx]) w_state_nxt = c_ST_READ;
                   else if (w_last) w_state_nxt = c_ST_COMMIT;
      c_ST_READ:   if (w_tmo) w_state_nxt = c_ST_IDLE;
                   else if (w_cdone) w_state_nxt = w_last ? c_ST_COMMIT : c_ST_SEL;
      c_ST_COMMIT: w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    w_idx_nxt     = r_idx;
    w_mode_nxt    = r_mode;
    w_emask_nxt   = r_emask;
    w_tmr_nxt     = r_tmr;
    w_shadow_nxt  = r_shadow;
    w_regs_nxt    = r_regs;
    w_valid_nxt   = r_valid;
    w_bus_req_nxt = r_bus_req;
    w_bus_out_nxt = r_bus_out;
    w_bus_wr_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    w_busy_nxt    = (w_state_nxt != c_ST_IDLE);
    case (r_state)
      c_ST_IDLE: begin
        w_bus_req_nxt = 1'b0;
        w_bus_out_nxt = IDLE_ADDR;
        if (start) begin
          w_bus_req_nxt = 1'b1;
          w_mode_nxt    = mode_timer;
          w_emask_nxt   = reg_mask & (mode_timer ? c_TMR_MASK : {NREG{1'b1}});
          w_tmr_nxt     = '0;
        end
      end
      c_ST_CMD, c_ST_READ: begin
        if (w_tmo) begin
          w_error_nxt   = 1'b1;
          w_bus_req_nxt = 1'b0;
          w_bus_out_nxt = IDLE_ADDR;
          w_tmr_nxt     = '0;
        end else if (w_addr) begin
          w_tmr_nxt     = '0;
          if (r_state == c_ST_CMD) w_bus_out_nxt = r_mode ? CMD_TMR : CMD_CLK;
          else                     w_bus_out_nxt = addr_tab[r_idx*DW +: DW];
        end else if (w_data) begin
          w_tmr_nxt = '0;
          if (r_state == c_ST_CMD) begin
            w_bus_out_nxt = CMD_DATA;
            w_bus_wr_nxt  = 1'b1;
          end else begin
            w_shadow_nxt[r_idx] = bus.rd_data;
          end
        end else if (w_cdone) begin
          w_tmr_nxt     = '0;
          w_bus_req_nxt = 1'b0;
          if (r_state == c_ST_CMD) w_idx_nxt = '0;
          else if (!w_last)        w_idx_nxt = r_idx + 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + 16'd1;
        end
      end
      c_ST_SEL: begin
        if (r_emask[r_idx]) begin
          w_bus_req_nxt = 1'b1;
          w_tmr_nxt     = '0;
        end else if (!w_last) begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      c_ST_COMMIT: begin
        for (int i = 0; i < NREG; i++)
          if (r_emask[i]) w_regs_nxt[i] = r_shadow[i];
        w_valid_nxt   = r_emask;
        w_done_nxt    = 1'b1;
        w_bus_out_nxt = IDLE_ADDR;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_mode    <= 1'b0;
      r_emask   <= '0;
      r_tmr     <= '0;
      r_shadow  <= '0;
      r_regs    <= '0;
      r_valid   <= '0;
      r_bus_req <= 1'b0;
      r_bus_out <= IDLE_ADDR;
      r_bus_wr  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_mode    <= w_mode_nxt;
      r_emask   <= w_emask_nxt;
      r_tmr     <= w_tmr_nxt;
      r_shadow  <= w_shadow_nxt;
      r_regs    <= w_regs_nxt;
      r_valid   <= w_valid_nxt;
      r_bus_req <= w_bus_req_nxt;
      r_bus_out <= w_bus_out_nxt;
      r_bus_wr  <= w_bus_wr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  assign bus.bus_req = r_bus_req;
  assign bus.bus_out = r_bus_out;
  assign bus.bus_wr  = r_bus_wr;
  assign regs_out    = r_regs;
  assign valid_mask  = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule

`default_nettype wire
